// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream in_* side, downstream out_* side,
// and the req/flush pipeline controls. The stage itself connects through the slave modport.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 136,
    parameter int PC_W   = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_data;
    logic              req;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_pc, in_data, req, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_pc, in_data, req, flush, out_ready,
        output in_ready, out_valid, out_pc, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, exception redirect and flush.
// Define PIPE_STAGE_SKID_EN for the two-entry (main + skid) variant; otherwise a single entry.
module pipe_stage_reg #(
    parameter int              DATA_W     = 136,
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = 'h0000_3000,
    parameter logic [PC_W-1:0] HANDLER_PC = 'h0000_4180
) (
    input logic           clk,
    input logic           reset,
    pipe_stage_reg_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   mainPc_q, mainPc_d;
    logic [DATA_W-1:0] mainData_q, mainData_d;
    logic              outValid;
    logic              inXfer;
    logic              outXfer;
`ifdef PIPE_STAGE_SKID_EN
    logic [PC_W-1:0]   skidPc_q, skidPc_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;
`endif

    assign outValid = (state_q != EMPTY);

    // The skid variant decides readiness from registers alone; the single entry
    // variant must look through to out_ready to keep full throughput.
`ifdef PIPE_STAGE_SKID_EN
    assign bus.in_ready = (state_q != FULL) & ~reset;
`else
    assign bus.in_ready = (~outValid | bus.out_ready) & ~reset;
`endif

    assign inXfer        = bus.in_valid & bus.in_ready;
    assign outXfer       = outValid & bus.out_ready;
    assign bus.out_valid = outValid;
    assign bus.out_pc    = mainPc_q;
    assign bus.out_data  = mainData_q;
    assign bus.occupancy = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            mainPc_q   <= RESET_PC;
            mainData_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skidPc_q   <= '0;
            skidData_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mainPc_q   <= mainPc_d;
            mainData_q <= mainData_d;
`ifdef PIPE_STAGE_SKID_EN
            skidPc_q   <= skidPc_d;
            skidData_q <= skidData_d;
`endif
        end
    end

    // req outranks flush; both discard any same-cycle input. A flush keeps mainPc so
    // the bubble carries the PC of the killed (or last departed) instruction.
    always_comb begin
        state_d    = state_q;
        mainPc_d   = mainPc_q;
        mainData_d = mainData_q;
`ifdef PIPE_STAGE_SKID_EN
        skidPc_d   = skidPc_q;
        skidData_d = skidData_q;
`endif
        if (bus.req) begin
            state_d    = EMPTY;
            mainPc_d   = HANDLER_PC;
            mainData_d = '0;
`ifdef PIPE_STAGE_SKID_EN
            skidData_d = '0;
`endif
        end else if (bus.flush) begin
            state_d    = EMPTY;
            mainData_d = '0;
`ifdef PIPE_STAGE_SKID_EN
            skidData_d = '0;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (inXfer) begin
                        state_d    = ONE;
                        mainPc_d   = bus.in_pc;
                        mainData_d = bus.in_data;
                    end
                end
                ONE: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (inXfer && outXfer) begin
                        mainPc_d   = bus.in_pc;
                        mainData_d = bus.in_data;
                    end else if (inXfer) begin
                        state_d    = FULL;
                        skidPc_d   = bus.in_pc;
                        skidData_d = bus.in_data;
                    end else if (outXfer) begin
                        state_d    = EMPTY;
                        mainData_d = '0;
                    end
`else
                    if (inXfer) begin
                        mainPc_d   = bus.in_pc;
                        mainData_d = bus.in_data;
                    end else if (outXfer) begin
                        state_d    = EMPTY;
                        mainData_d = '0;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                FULL: begin
                    if (outXfer) begin
                        state_d    = ONE;
                        mainPc_d   = skidPc_q;
                        mainData_d = skidData_q;
                        skidData_d = '0;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end
endmodule
